// File: rtl/addr_debounce_bank_if.sv
// Shared address/read bus between a decoder (master) and debounce banks (slave).
interface addr_debounce_bank_if #(
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 3
);
    logic [ADDR_W-1:0]   aBus;
    logic                rd;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] changed;
    logic                sel;

    modport master (output aBus, output rd, input out, input changed, input sel);
    modport slave  (input aBus, input rd, output out, output changed, output sel);
endinterface

// File: rtl/addr_debounce_bank.sv
// Bank of complementary-contact switch debouncers with sticky change/fault flags,
// presented on a shared bus when the strapped address matches.
module addr_debounce_bank #(
    parameter int CHANNELS    = 8,
    parameter int ADDR_W      = 3,
    parameter int CNT_W       = 4,
    parameter int DEB_CYCLES  = 10,
    parameter int ADDR_INVERT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2*CHANNELS-1:0] in,
    input  logic [ADDR_W-1:0]     addr,
    output logic [CHANNELS-1:0]   fault,
    output logic                  irq,
    addr_debounce_bank_if.slave   bus
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CHANNELS-1:0][CNT_W-1:0] cnt;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_nxt;
    logic [CHANNELS-1:0]            stable;
    logic [CHANNELS-1:0]            stable_nxt;
    logic [CHANNELS-1:0]            chg;
    logic [CHANNELS-1:0]            chg_pre;
    logic [CHANNELS-1:0]            chg_nxt;
    logic [CHANNELS-1:0]            fault_nxt;
    logic [CHANNELS-1:0]            acc;
    logic [CHANNELS-1:0]            fset;
    logic                           match;
    logic                           clr;

    assign match = (bus.aBus == ((ADDR_INVERT != 0) ? ~addr : addr));
    assign clr   = bus.rd & match;

    // Pair 00 is a contact in transit: everything holds. Pair 11 is illegal.
    always_comb begin
        cnt_nxt    = cnt;
        stable_nxt = stable;
        acc        = '0;
        fset       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case ({in[2*i+1], in[2*i]})
                2'b11: begin
                    cnt_nxt[i] = '0;
                    fset[i]    = 1'b1;
                end
                2'b10, 2'b01: begin
                    if (in[2*i+1] == stable[i]) begin
                        cnt_nxt[i] = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        cnt_nxt[i]    = '0;
                        stable_nxt[i] = in[2*i+1];
                        acc[i]        = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A read returns flags including same-edge events; new events survive the clear.
    assign chg_pre   = chg | acc;
    assign chg_nxt   = (clr ? '0 : chg) | acc;
    assign fault_nxt = (clr ? '0 : fault) | fset;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            stable      <= '0;
            chg         <= '0;
            fault       <= '0;
            irq         <= 1'b0;
            bus.sel     <= 1'b0;
            bus.out     <= '0;
            bus.changed <= '0;
        end else begin
            cnt         <= cnt_nxt;
            stable      <= stable_nxt;
            chg         <= chg_nxt;
            fault       <= fault_nxt;
            irq         <= |chg_nxt;
            bus.sel     <= match;
            bus.out     <= match ? stable_nxt : '0;
            bus.changed <= match ? chg_pre : '0;
        end
    end
endmodule

// File: tb/tb_addr_debounce_bank.sv
// Bench for addr_debounce_bank: directed corner sequences, a decode table and
// randomized traffic against a per-channel run-length reference model.
module tb_addr_debounce_bank;
    localparam int CH  = 8;
    localparam int AW  = 3;
    localparam int DEB = 10;

    logic            clk;
    logic            rst;
    logic [2*CH-1:0] in_pairs;
    logic [AW-1:0]   addr;
    logic [CH-1:0]   fault;
    logic            irq;

    int checks = 0;
    int errors = 0;

    addr_debounce_bank_if #(.CHANNELS(CH), .ADDR_W(AW)) bus_if ();

    addr_debounce_bank #(
        .CHANNELS(CH), .ADDR_W(AW), .CNT_W(4), .DEB_CYCLES(DEB), .ADDR_INVERT(1)
    ) dut (
        .clk(clk), .rst(rst), .in(in_pairs), .addr(addr),
        .fault(fault), .irq(irq), .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: each channel remembers its accepted level and how many
    // consecutive valid samples have disagreed with it
    bit [CH-1:0] m_stable;
    int          m_run [CH];
    bit [CH-1:0] m_chg, m_fault, m_out, m_changed;
    bit          m_sel, m_irq;

    task automatic model_update();
        bit          match;
        bit [CH-1:0] acc, fset;
        bit [1:0]    p;
        if (rst) begin
            m_stable = '0; m_chg = '0; m_fault = '0; m_out = '0; m_changed = '0;
            m_sel = 1'b0; m_irq = 1'b0;
            for (int i = 0; i < CH; i++) m_run[i] = 0;
            return;
        end
        match = (bus_if.aBus == ~addr);
        acc = '0; fset = '0;
        for (int i = 0; i < CH; i++) begin
            p = in_pairs[2*i +: 2];
            if (p == 2'b11) begin
                m_run[i] = 0;
                fset[i]  = 1'b1;
            end else if (p != 2'b00) begin
                if ((p == 2'b10) == m_stable[i]) m_run[i] = 0;
                else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = ~m_stable[i];
                        m_run[i]    = 0;
                        acc[i]      = 1'b1;
                    end
                end
            end
        end
        m_changed = match ? (m_chg | acc) : '0;
        if (match && bus_if.rd) begin
            m_chg = '0; m_fault = '0;
        end
        m_chg   |= acc;
        m_fault |= fset;
        m_out = match ? m_stable : '0;
        m_sel = match;
        m_irq = |m_chg;
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk8("model_out", bus_if.out, m_out);
        chk8("model_changed", bus_if.changed, m_changed);
        chk8("model_fault", fault, m_fault);
        chk1("model_sel", bus_if.sel, m_sel);
        chk1("model_irq", irq, m_irq);
    endtask

    task automatic set_pair(input int ch, input logic [1:0] p);
        in_pairs[2*ch +: 2] = p;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] abus;
        logic          rd;
        logic          sel;
        logic [CH-1:0] out;
        logic [CH-1:0] changed;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{3'b111, 3'b000, 1'b0, 1'b1, 8'h01, 8'h00};
        tbl[1] = '{3'b111, 3'b001, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[2] = '{3'b000, 3'b111, 1'b0, 1'b1, 8'h01, 8'h00};
        tbl[3] = '{3'b101, 3'b010, 1'b0, 1'b1, 8'h01, 8'h00};
        tbl[4] = '{3'b101, 3'b101, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[5] = '{3'b110, 3'b001, 1'b1, 1'b1, 8'h01, 8'h00};
        tbl[6] = '{3'b011, 3'b100, 1'b0, 1'b1, 8'h01, 8'h00};
        tbl[7] = '{3'b011, 3'b011, 1'b1, 1'b0, 8'h00, 8'h00};

        for (int i = 0; i < CH; i++) m_run[i] = 0;
        rst = 1'b1; addr = 3'b111; bus_if.aBus = 3'b000; bus_if.rd = 1'b0;
        in_pairs = 16'h5555;
        step(); step();
        chk8("reset_out", bus_if.out, 8'h00);
        chk1("reset_sel", bus_if.sel, 1'b0);
        chk1("reset_irq", irq, 1'b0);
        rst = 1'b0;
        step();
        chk1("sel_after_reset", bus_if.sel, 1'b1);
        chk8("out_after_reset", bus_if.out, 8'h00);
        chk1("irq_after_reset", irq, 1'b0);

        // clean transition on channel 0 accepted on the tenth edge
        set_pair(0, 2'b10);
        for (int k = 1; k <= DEB; k++) begin
            step();
            if (k < DEB) chk1("ch0_before_accept", bus_if.out[0], 1'b0);
        end
        chk1("ch0_accept", bus_if.out[0], 1'b1);
        chk1("ch0_changed", bus_if.changed[0], 1'b1);
        chk1("ch0_irq", irq, 1'b1);

        // bouncing every 4 cycles never completes a count
        for (int k = 0; k < 40; k++) begin
            set_pair(3, ((k / 4) % 2 == 0) ? 2'b10 : 2'b01);
            step();
        end
        set_pair(3, 2'b01);
        chk1("ch3_bounce_out", bus_if.out[3], 1'b0);
        chk1("ch3_bounce_changed", bus_if.changed[3], 1'b0);

        // transit (00) pauses the count; 11 flags a fault and restarts it
        set_pair(5, 2'b10); repeat (4) step();
        set_pair(5, 2'b00); repeat (6) step();
        set_pair(5, 2'b10); repeat (5) step();
        chk1("ch5_paused", bus_if.out[5], 1'b0);
        step();
        chk1("ch5_accept", bus_if.out[5], 1'b1);
        set_pair(5, 2'b01); repeat (3) step();
        set_pair(5, 2'b11); step();
        chk1("ch5_fault", fault[5], 1'b1);
        set_pair(5, 2'b01); repeat (DEB - 1) step();
        chk1("ch5_restarted", bus_if.out[5], 1'b1);
        step();
        chk1("ch5_fall_accept", bus_if.out[5], 1'b0);

        // unselected reads do nothing; selected read returns and clears
        bus_if.aBus = 3'b001; step();
        chk8("unsel_out", bus_if.out, 8'h00);
        chk8("unsel_changed", bus_if.changed, 8'h00);
        chk1("unsel_sel", bus_if.sel, 1'b0);
        bus_if.rd = 1'b1; step();
        chk1("unsel_rd_irq", irq, 1'b1);
        bus_if.aBus = 3'b000; step();
        chk8("read_changed", bus_if.changed, 8'h21);
        chk8("read_fault_cleared", fault, 8'h00);
        chk1("read_irq_cleared", irq, 1'b0);
        bus_if.rd = 1'b0; step();
        chk8("after_read_changed", bus_if.changed, 8'h00);

        // address decode table
        for (int v = 0; v < 8; v++) begin
            addr = tbl[v].addr; bus_if.aBus = tbl[v].abus; bus_if.rd = tbl[v].rd;
            step();
            chk1("tbl_sel", bus_if.sel, tbl[v].sel);
            chk8("tbl_out", bus_if.out, tbl[v].out);
            chk8("tbl_changed", bus_if.changed, tbl[v].changed);
        end
        addr = 3'b111; bus_if.aBus = 3'b000; bus_if.rd = 1'b0;

        // acceptance on the same edge as a clearing read survives
        set_pair(1, 2'b10); repeat (DEB - 1) step();
        bus_if.rd = 1'b1; step();
        chk1("ch1_read_edge", bus_if.changed[1], 1'b1);
        bus_if.rd = 1'b0; step();
        chk1("ch1_set_wins", bus_if.changed[1], 1'b1);
        chk1("ch1_irq", irq, 1'b1);

        // reset mid-count
        set_pair(2, 2'b10); repeat (5) step();
        rst = 1'b1; step();
        chk8("midrst_out", bus_if.out, 8'h00);
        chk8("midrst_changed", bus_if.changed, 8'h00);
        chk8("midrst_fault", fault, 8'h00);
        chk1("midrst_sel", bus_if.sel, 1'b0);
        chk1("midrst_irq", irq, 1'b0);
        rst = 1'b0; step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < CH; i++) begin
                automatic int r = $urandom_range(0, 299);
                if (r < 18) set_pair(i, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
                else if (r < 21) set_pair(i, 2'b00);
                else if (r == 21) set_pair(i, 2'b11);
            end
            if ($urandom_range(0, 9) == 0)
                bus_if.aBus = ($urandom_range(0, 1) != 0) ? ~addr : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) addr = 3'($urandom_range(0, 7));
            bus_if.rd = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
